vga_dac_port_fml: RTL and testbench
===================================

VGA_DAC_PORT_FML -- requirements
Module: vga_dac_port_fml

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous reset, active-low
- io_addr  in  4  port offset within 0x3C0-0x3CF
- io_wr  in  1  one-cycle write strobe
- io_rd  in  1  one-cycle read strobe
- io_wdata  in  8  write data
- io_rdata  out  8  read data, registered
- io_ack  out  1  one-cycle access completion pulse
- attr_ff_clr  in  1  one-cycle pulse on an input-status (0x3DA) read
- pal_addr  out  4  palette register index
- pal_we  out  1  palette write pulse
- pal_write  out  8  palette write data
- pal_read  in  8  palette read data, 1-cycle latency
- pal_enable  out  1  attribute index bit 5 (PAS)
- pel_mask  out  8  PEL mask register
- dac_we  out  1  DAC write pulse
- dac_write_data_cycle  out  2  0=R, 1=G, 2=B
- dac_write_data_register  out  8  DAC write index
- dac_write_data  out  4  DAC write component
- dac_read_data_cycle  out  2  0=R, 1=G, 2=B
- dac_read_data_register  out  8  DAC read index
- dac_read_data  in  4  DAC read component, 1-cycle latency

Function
REQ-002 Accesses: a strobe accepted at cycle T SHALL produce io_ack at T+1 for a write and at T+2 for a read; io_rdata SHALL be valid during the ack cycle and SHALL hold until the next read ack.
REQ-003 Strobes arriving while an access is pending (before its ack) SHALL be ignored; if io_wr and io_rd are asserted together, the write SHALL win and the read SHALL be dropped (no ack).
REQ-004 Attribute flip-flop ff: 0=address phase, 1=data phase.
REQ-005 Write 0x3C0 with ff=0: attr_index <= io_wdata[4:0], pal_enable <= io_wdata[5], ff <= 1.
REQ-006 Write 0x3C0 with ff=1: if attr_index<16, pal_we SHALL pulse for exactly 1 cycle (T+1) with pal_addr=attr_index[3:0] and pal_write=io_wdata; if attr_index>=16, the data SHALL be discarded; in both cases ff <= 0.
REQ-007 attr_ff_clr SHALL force ff to 0; when it coincides with a 0x3C0 write, the write SHALL be decoded using the pre-clear ff, and ff SHALL end at 0.
REQ-008 Read 0x3C0 SHALL return {2'b00, pal_enable, attr_index}; read 0x3C1 SHALL return pal_read if attr_index<16, else 8'h00; reads SHALL NOT change ff.
REQ-009 0x3C6: a write SHALL load pel_mask; a read SHALL return pel_mask.
REQ-010 Write 0x3C7: rd_index <= io_wdata, rd_cycle <= 0, dac_state <= 2'b11. Read 0x3C7 SHALL return {6'b0, dac_state}.
REQ-011 Write 0x3C8: wr_index <= io_wdata, wr_cycle <= 0, dac_state <= 2'b00. Read 0x3C8 SHALL return wr_index.
REQ-012 Write 0x3C9: dac_we SHALL pulse for 1 cycle with dac_write_data=io_wdata[5:2] and the current wr_cycle/wr_index; wr_cycle SHALL then advance 0->1->2->0, and wr_index SHALL increment modulo 256 on the 2->0 wrap.
REQ-013 Read 0x3C9: the block SHALL drive the current rd_cycle/rd_index, return {2'b00, dac_read_data, 2'b00}, then advance rd_cycle/rd_index by the same rule as REQ-012.
REQ-014 dac_*_register and dac_*_cycle outputs SHALL continuously reflect the wr/rd index and cycle registers.
REQ-015 Accesses to other offsets SHALL be acked, with read data 8'h00 and no state change.

Reset
REQ-016 While rst=0 at a clock edge: ff=0, attr_index=0, pal_enable=0, pel_mask=8'hFF, wr/rd index=0, wr/rd cycle=0, dac_state=2'b00, io_rdata=0, and io_ack, pal_we, dac_we=0; any pending access SHALL be abandoned without an ack.

Verification
REQ-017 Write 0x3C0=0x25, then 0x3C0=0x3F -> pal_we pulses 1 cycle with pal_addr=5, pal_write=0x3F; pal_enable=1; ff=0.
REQ-018 Write 0x3C0=0x12, then 0x3C0=0x55 -> no pal_we; the subsequent read of 0x3C0 returns 0x12.
REQ-019 Write 0x3C0=0x03, pulse attr_ff_clr, write 0x3C0=0x07 -> no pal_we; attr_index=7.
REQ-020 Write 0x3C8=0xFF, then three 0x3C9 writes (0x3C, 0x00, 0x04) -> dac_we with cycles 0, 1, 2 at index 0xFF and data 0xF, 0x0, 0x1; wr_index wraps to 0x00.
REQ-021 Write 0x3C7=0x10, read 0x3C9 four times -> acks at T+2; rd_cycle/register sequence (0,0x10), (1,0x10), (2,0x10), (0,0x11); the read of 0x3C7 returns 0x03.
REQ-022 Assert rst low during a pending 0x3C9 read -> no ack; all registers at reset values; pel_mask=0xFF.

Source files
------------

// File: rtl/vga_dac_port_fml.sv
// vga_dac_port_fml
//   Register front end for the VGA attribute controller port (0x3C0/0x3C1)
//   and the DAC ports (0x3C6-0x3C9).
//
//   Handshake: io_wr/io_rd are one-cycle strobes, and there is no ready signal.
//   A strobe seen at a clock edge is accepted unless a read is already pending.
//   A write is acked one cycle later. A read is acked two cycles later because
//   the palette and DAC arrays answer with one cycle of latency. io_rdata is
//   valid in the read ack cycle and holds until the next read ack. Strobes that
//   arrive while a read is pending are dropped. When both strobes arrive
//   together, the write is taken and the read is dropped.
//
//   Ports:
//     clk, rst (sync, active-low)
//     io_addr/io_wr/io_rd/io_wdata/io_rdata/io_ack : CPU I/O access
//     attr_ff_clr                   : clears the attribute flip-flop (0x3DA read)
//     pal_addr/pal_we/pal_write/pal_read/pal_enable : attribute palette side
//     pel_mask                      : PEL mask register
//     dac_we/dac_write_data_*       : DAC write side
//     dac_read_data_*/dac_read_data : DAC read side
module vga_dac_port_fml (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] io_addr,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       io_ack,
   input  logic       attr_ff_clr,
   output logic [3:0] pal_addr,
   output logic       pal_we,
   output logic [7:0] pal_write,
   input  logic [7:0] pal_read,
   output logic       pal_enable,
   output logic [7:0] pel_mask,
   output logic       dac_we,
   output logic [1:0] dac_write_data_cycle,
   output logic [7:0] dac_write_data_register,
   output logic [3:0] dac_write_data,
   output logic [1:0] dac_read_data_cycle,
   output logic [7:0] dac_read_data_register,
   input  logic [3:0] dac_read_data
);

   logic       ff;          // 0 = attribute address phase, 1 = data phase
   logic [4:0] attr_index;
   logic       rd_pend;     // a read has been accepted and is waiting for its ack
   logic [3:0] rd_addr;
   logic [1:0] dac_state;
   logic [7:0] wr_index;
   logic [7:0] rd_index;
   logic [1:0] wr_cycle;
   logic [1:0] rd_cycle;
   logic [7:0] rd_mux;
   logic       accept_wr;
   logic       accept_rd;

   assign accept_wr = io_wr && !rd_pend;
   assign accept_rd = io_rd && !io_wr && !rd_pend;

   assign pal_addr                = attr_index[3:0];
   assign dac_write_data_cycle    = wr_cycle;
   assign dac_write_data_register = wr_index;
   assign dac_read_data_cycle     = rd_cycle;
   assign dac_read_data_register  = rd_index;

   // Read data selection. This is sampled one cycle after the read was
   // accepted, so pal_read and dac_read_data already reflect the index.
   always_comb begin
      rd_mux = 8'h00;
      case (rd_addr)
         4'h0: rd_mux = {2'b00, pal_enable, attr_index};
         4'h1: rd_mux = attr_index[4] ? 8'h00 : pal_read;
         4'h6: rd_mux = pel_mask;
         4'h7: rd_mux = {6'b0, dac_state};
         4'h8: rd_mux = wr_index;
         4'h9: rd_mux = {2'b00, dac_read_data, 2'b00};
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ff             <= 1'b0;
         attr_index     <= 5'd0;
         pal_enable     <= 1'b0;
         pel_mask       <= 8'hFF;
         wr_index       <= 8'h00;
         rd_index       <= 8'h00;
         wr_cycle       <= 2'd0;
         rd_cycle       <= 2'd0;
         dac_state      <= 2'b00;
         io_rdata       <= 8'h00;
         io_ack         <= 1'b0;
         pal_we         <= 1'b0;
         pal_write      <= 8'h00;
         dac_we         <= 1'b0;
         dac_write_data <= 4'h0;
         rd_pend        <= 1'b0;
         rd_addr        <= 4'h0;
      end else begin
         io_ack <= 1'b0;
         pal_we <= 1'b0;
         dac_we <= 1'b0;

         // The write cursor advances after the dac_we cycle, so the DAC sees
         // the cycle and index that belong to the component being written.
         // A 0x3C8 write accepted in the same cycle overrides this below.
         if (dac_we) begin
            if (wr_cycle == 2'd2) begin
               wr_cycle <= 2'd0;
               wr_index <= wr_index + 8'd1;
            end else begin
               wr_cycle <= wr_cycle + 2'd1;
            end
         end

         if (rd_pend) begin
            rd_pend  <= 1'b0;
            io_ack   <= 1'b1;
            io_rdata <= rd_mux;
            if (rd_addr == 4'h9) begin
               if (rd_cycle == 2'd2) begin
                  rd_cycle <= 2'd0;
                  rd_index <= rd_index + 8'd1;
               end else begin
                  rd_cycle <= rd_cycle + 2'd1;
               end
            end
         end

         if (accept_wr) begin
            io_ack <= 1'b1;
            case (io_addr)
               4'h0: begin
                  if (!ff) begin
                     attr_index <= io_wdata[4:0];
                     pal_enable <= io_wdata[5];
                     ff         <= 1'b1;
                  end else begin
                     // Indices 16..31 are not palette entries: drop the data.
                     if (!attr_index[4]) begin
                        pal_we    <= 1'b1;
                        pal_write <= io_wdata;
                     end
                     ff <= 1'b0;
                  end
               end
               4'h6: pel_mask <= io_wdata;
               4'h7: begin
                  rd_index  <= io_wdata;
                  rd_cycle  <= 2'd0;
                  dac_state <= 2'b11;
               end
               4'h8: begin
                  wr_index  <= io_wdata;
                  wr_cycle  <= 2'd0;
                  dac_state <= 2'b00;
               end
               4'h9: begin
                  dac_we         <= 1'b1;
                  dac_write_data <= io_wdata[5:2];
               end
               default: ;
            endcase
         end

         if (accept_rd) begin
            rd_pend <= 1'b1;
            rd_addr <= io_addr;
         end

         // The clear comes last: a coincident 0x3C0 write was decoded with
         // the old ff above, but ff still ends at 0.
         if (attr_ff_clr) ff <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_dac_port_fml.sv
// tb_vga_dac_port_fml
//   Directed bench for vga_dac_port_fml. Read data and palette/DAC write
//   events are checked against expected queues.
module tb_vga_dac_port_fml;

   logic       clk;
   logic       rst;
   logic [3:0] io_addr;
   logic       io_wr;
   logic       io_rd;
   logic [7:0] io_wdata;
   logic [7:0] io_rdata;
   logic       io_ack;
   logic       attr_ff_clr;
   logic [3:0] pal_addr;
   logic       pal_we;
   logic [7:0] pal_write;
   logic [7:0] pal_read;
   logic       pal_enable;
   logic [7:0] pel_mask;
   logic       dac_we;
   logic [1:0] dac_write_data_cycle;
   logic [7:0] dac_write_data_register;
   logic [3:0] dac_write_data;
   logic [1:0] dac_read_data_cycle;
   logic [7:0] dac_read_data_register;
   logic [3:0] dac_read_data;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];   // expected read data, in order of reads
   logic [11:0] pal_q[$];   // expected {pal_addr, pal_write}
   logic [13:0] dac_q[$];   // expected {cycle, register, data}

   vga_dac_port_fml dut (
      .clk(clk), .rst(rst),
      .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack), .attr_ff_clr(attr_ff_clr),
      .pal_addr(pal_addr), .pal_we(pal_we), .pal_write(pal_write),
      .pal_read(pal_read), .pal_enable(pal_enable), .pel_mask(pel_mask),
      .dac_we(dac_we), .dac_write_data_cycle(dac_write_data_cycle),
      .dac_write_data_register(dac_write_data_register),
      .dac_write_data(dac_write_data),
      .dac_read_data_cycle(dac_read_data_cycle),
      .dac_read_data_register(dac_read_data_register),
      .dac_read_data(dac_read_data)
   );

   // Clock and reset: 100 MHz
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array models with one cycle of read latency. The palette returns
   // {idx, ~idx}. The DAC returns index[3:0] ^ cycle.
   always @(posedge clk) begin
      pal_read      <= {pal_addr, ~pal_addr};
      dac_read_data <= dac_read_data_register[3:0] ^ {2'b00, dac_read_data_cycle};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each palette or DAC write pulse must match the oldest queued expectation.
   // A pulse that lasts one cycle too long has nothing left to match.
   always @(negedge clk) begin
      if (pal_we) begin
         if (pal_q.size() == 0) chk("pal_we_unexpected", {pal_addr, pal_write}, 32'hFFFF_FFFF);
         else chk("pal_we_event", {pal_addr, pal_write}, pal_q.pop_front());
      end
      if (dac_we) begin
         if (dac_q.size() == 0)
            chk("dac_we_unexpected", {dac_write_data_cycle, dac_write_data_register, dac_write_data}, 32'hFFFF_FFFF);
         else
            chk("dac_we_event", {dac_write_data_cycle, dac_write_data_register, dac_write_data}, dac_q.pop_front());
      end
   end

   // Driver tasks. Each is entered 1 time unit after a rising edge.
   task automatic io_write(input logic [3:0] a, input logic [7:0] d);
      io_addr = a; io_wdata = d; io_wr = 1'b1;
      @(posedge clk); #1;
      io_wr = 1'b0;
      chk("wr_ack", io_ack, 1);
   endtask

   task automatic wait_read_ack(input string tag);
      int n;
      n = 0;
      chk({tag, "_no_early_ack"}, io_ack, 0);
      while (!io_ack && n < 4) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, 1);
      if (exp_q.size() != 0) chk({tag, "_data"}, io_rdata, exp_q.pop_front());
   endtask

   task automatic io_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
      exp_q.push_back(exp);
      io_addr = a; io_rd = 1'b1;
      @(posedge clk); #1;
      io_rd = 1'b0;
      wait_read_ack(tag);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; io_addr = 4'h0; io_wr = 1'b0; io_rd = 1'b0;
      io_wdata = 8'h00; attr_ff_clr = 1'b0;
      repeat (3) tick();
      chk("rst_ack", io_ack, 0);
      chk("rst_pel_mask", pel_mask, 8'hFF);
      chk("rst_pal_enable", pal_enable, 0);
      chk("rst_rdata", io_rdata, 0);
      chk("rst_pal_we", pal_we, 0);
      chk("rst_dac_we", dac_we, 0);
      chk("rst_dac_regs", {dac_write_data_register, dac_write_data_cycle,
                           dac_read_data_register, dac_read_data_cycle}, 0);
      rst = 1'b1;
      tick();
      io_read(4'h6, 8'hFF, "rd_pel_reset");
      io_read(4'h0, 8'h00, "rd_attr_reset");

      // Attribute write: the first write selects the index, the second writes data.
      io_write(4'h0, 8'h25);
      pal_q.push_back({4'h5, 8'h3F});
      io_write(4'h0, 8'h3F);
      chk("pal_enable_set", pal_enable, 1);
      io_read(4'h0, 8'h25, "rd_attr_25");
      // An index of 16 or more drops the data.
      io_write(4'h0, 8'h12);
      io_write(4'h0, 8'h55);
      io_read(4'h0, 8'h12, "rd_attr_12");
      io_read(4'h1, 8'h00, "rd_3c1_hi_index");
      // Palette read, then check that the read left ff unchanged.
      io_write(4'h0, 8'h05);
      io_read(4'h1, 8'h5A, "rd_3c1_pal");
      pal_q.push_back({4'h5, 8'h77});
      io_write(4'h0, 8'h77);

      // A flip-flop clear between writes turns the second write into an address write.
      io_write(4'h0, 8'h03);
      attr_ff_clr = 1'b1; tick(); attr_ff_clr = 1'b0;
      io_write(4'h0, 8'h07);
      io_read(4'h0, 8'h07, "rd_attr_after_clr");
      // A clear that coincides with the data write: the data is written and ff ends at 0.
      pal_q.push_back({4'h7, 8'h44});
      attr_ff_clr = 1'b1;
      io_write(4'h0, 8'h44);
      attr_ff_clr = 1'b0;
      io_write(4'h0, 8'h09);
      io_read(4'h0, 8'h09, "rd_attr_coincident_clr");
      io_write(4'h0, 8'h0B);   // data phase, returns ff to 0
      pal_q.push_back({4'h9, 8'h0B});

      io_write(4'h6, 8'h5A);
      chk("pel_mask_out", pel_mask, 8'h5A);
      io_read(4'h6, 8'h5A, "rd_pel");

      // DAC write sequence with index wrap
      io_write(4'h8, 8'hFF);
      io_read(4'h8, 8'hFF, "rd_wr_index");
      dac_q.push_back({2'd0, 8'hFF, 4'hF});
      io_write(4'h9, 8'h3C);
      dac_q.push_back({2'd1, 8'hFF, 4'h0});
      io_write(4'h9, 8'h00);
      dac_q.push_back({2'd2, 8'hFF, 4'h1});
      io_write(4'h9, 8'h04);
      tick();
      chk("wr_wrap", {dac_write_data_register, dac_write_data_cycle}, {8'h00, 2'd0});
      io_read(4'h7, 8'h00, "rd_dac_state_wr");

      // DAC read sequence
      io_write(4'h7, 8'h10);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] c;
         logic [7:0] r;
         c = 2'(i % 3);
         r = 8'h10 + 8'(i / 3);
         chk("rd_cursor", {dac_read_data_cycle, dac_read_data_register}, {c, r});
         io_read(4'h9, {2'b00, r[3:0] ^ {2'b00, c}, 2'b00}, "rd_3c9");
      end
      chk("rd_cursor_end", {dac_read_data_cycle, dac_read_data_register}, {2'd1, 8'h11});
      io_read(4'h7, 8'h03, "rd_dac_state_rd");

      // Simultaneous strobes: the write wins and the read gets no ack.
      io_addr = 4'h6; io_wdata = 8'h33; io_wr = 1'b1; io_rd = 1'b1;
      tick();
      io_wr = 1'b0; io_rd = 1'b0;
      chk("both_wr_ack", io_ack, 1);
      tick(); chk("both_no_rd_ack1", io_ack, 0);
      tick(); chk("both_no_rd_ack2", io_ack, 0);
      io_read(4'h6, 8'h33, "rd_pel_33");

      // A write that arrives while a read is pending is ignored.
      exp_q.push_back(8'h33);
      io_addr = 4'h6; io_rd = 1'b1;
      tick();
      io_rd = 1'b0; io_wdata = 8'h99; io_wr = 1'b1;
      chk("pend_no_ack", io_ack, 0);
      tick();
      io_wr = 1'b0;
      chk("pend_rd_ack", io_ack, 1);
      chk("pend_rd_data", io_rdata, exp_q.pop_front());
      tick(); chk("pend_wr_no_ack", io_ack, 0);
      io_read(4'h6, 8'h33, "rd_pel_unchanged");

      // Other offsets are acked, read as zero, and change nothing.
      io_write(4'h2, 8'hA5);
      io_read(4'hF, 8'h00, "rd_other");
      io_read(4'h6, 8'h33, "rd_pel_after_other");

      // Reset while a 0x3C9 read is pending
      io_write(4'h8, 8'h40);
      io_write(4'h0, 8'h0A);   // leaves ff at 1
      io_addr = 4'h9; io_rd = 1'b1;
      tick();
      io_rd = 1'b0; rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_abort_ack0", io_ack, 0);
      tick(); chk("rst_abort_ack1", io_ack, 0);
      tick(); chk("rst_abort_ack2", io_ack, 0);
      chk("rst2_pel_mask", pel_mask, 8'hFF);
      chk("rst2_pal_enable", pal_enable, 0);
      chk("rst2_dac_regs", {dac_write_data_register, dac_write_data_cycle,
                            dac_read_data_register, dac_read_data_cycle}, 0);
      io_read(4'h7, 8'h00, "rd_dac_state_rst");
      io_read(4'h0, 8'h00, "rd_attr_rst");
      io_write(4'h0, 8'h26);   // ff was cleared, so this is an address write
      io_read(4'h0, 8'h26, "rd_attr_ff_rst");

      repeat (2) tick();
      chk("pal_q_empty", pal_q.size(), 0);
      chk("dac_q_empty", dac_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
